// File: rtl/kyber_hw_pkg.sv
// Shared constants and FSM encoding for the polynomial bank stream adapters.
package kyber_hw_pkg;

  localparam int unsigned COEF_WIDTH = 12;
  localparam int unsigned POLY_WORDS = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_EMIT_LO  = 3'd4,
    ST_EMIT_HI  = 3'd5,
    ST_FIN      = 3'd6
  } pbs_state_e;

endpackage

// File: rtl/poly_bank_streamer.sv
// Packs a coefficient stream into two-coefficient bank words (LOAD) and
// unpacks bank words back into a coefficient stream (DUMP).
module poly_bank_streamer
  import kyber_hw_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = POLY_WORDS,
  parameter int unsigned COEF_W     = COEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic                  start_dump,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COEF_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COEF_W-1:0]     out_data,
  output logic                  bank_wen,
  output logic [ADDR_WIDTH-1:0] bank_waddr,
  output logic [2*COEF_W-1:0]   bank_din,
  output logic [ADDR_WIDTH-1:0] bank_raddr,
  input  logic [2*COEF_W-1:0]   bank_dout
);

  localparam int unsigned WORD_W = 2 * COEF_W;

  pbs_state_e              r_state;
  pbs_state_e              w_next;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_half;
  logic [COEF_W-1:0]       r_lo;
  logic [WORD_W-1:0]       r_hold;
  logic [ADDR_WIDTH-1:0]   r_raddr;

  logic                    w_cnt_clr;
  logic                    w_cnt_inc;
  logic                    w_lo_ld;
  logic                    w_hold_ld;
  logic                    w_last;

  assign w_last     = (r_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign bank_waddr = r_cnt;

  // Next-state and output decode
  always_comb begin
    w_next     = r_state;
    busy       = (r_state != ST_IDLE);
    done       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = r_hold[COEF_W-1:0];
    bank_wen   = 1'b0;
    bank_din   = '0;
    bank_raddr = r_raddr;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_lo_ld    = 1'b0;
    w_hold_ld  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_load) begin
          w_next    = ST_LOAD;
          w_cnt_clr = 1'b1;
        end else if (start_dump) begin
          w_next    = ST_RD_ISSUE;
          w_cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        // A reset on this edge must not let a write slip through to the bank.
        if (in_valid && !rst) begin
          if (r_half) begin
            bank_wen = 1'b1;
            bank_din = {in_data, r_lo};
            if (w_last) w_next = ST_FIN;
            else        w_cnt_inc = 1'b1;
          end else begin
            w_lo_ld = 1'b1;
          end
        end
      end
      ST_RD_ISSUE: begin
        bank_raddr = r_cnt;
        w_next     = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        w_hold_ld = 1'b1;
        w_next    = ST_EMIT_LO;
      end
      ST_EMIT_LO: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_EMIT_HI;
      end
      ST_EMIT_HI: begin
        out_valid = 1'b1;
        out_data  = r_hold[WORD_W-1:COEF_W];
        if (out_ready) begin
          if (w_last) begin
            w_next = ST_FIN;
          end else begin
            w_cnt_inc = 1'b1;
            w_next    = ST_RD_ISSUE;
          end
        end
      end
      ST_FIN: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, counter and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_half  <= 1'b0;
      r_lo    <= '0;
      r_hold  <= '0;
      r_raddr <= '0;
    end else begin
      r_state <= w_next;
      r_raddr <= bank_raddr;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + ADDR_WIDTH'(1);
      if (w_cnt_clr)      r_half <= 1'b0;
      else if (w_lo_ld)   r_half <= 1'b1;
      else if (bank_wen)  r_half <= 1'b0;
      if (w_lo_ld)   r_lo   <= in_data;
      if (w_hold_ld) r_hold <= bank_dout;
    end
  end

endmodule

// File: tb/tb_poly_bank_streamer.sv
// Bench for poly_bank_streamer paired with a registered-read bank model.
module tb_poly_bank_streamer;
  import kyber_hw_pkg::*;

  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned CW    = 12;
  localparam int unsigned NC    = 2 * DEPTH;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_load, start_dump;
  logic            busy, done;
  logic            in_valid, in_ready;
  logic [CW-1:0]   in_data;
  logic            out_valid, out_ready;
  logic [CW-1:0]   out_data;
  logic            bank_wen;
  logic [AW-1:0]   bank_waddr, bank_raddr;
  logic [2*CW-1:0] bank_din, bank_dout;

  always #5 clk = ~clk;

  poly_bank_streamer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .COEF_W(CW)) dut (
    .clk(clk), .rst(rst),
    .start_load(start_load), .start_dump(start_dump),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_din(bank_din),
    .bank_raddr(bank_raddr), .bank_dout(bank_dout)
  );

  // Bank: synchronous write, registered read address
  logic [2*CW-1:0] mem [DEPTH];
  logic [AW-1:0]   r_baddr;
  always @(posedge clk) begin
    if (bank_wen) mem[bank_waddr] <= bank_din;
    r_baddr <= bank_raddr;
  end
  assign bank_dout = mem[r_baddr];

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int wen_cnt = 0;
  int done_cnt = 0;
  logic [CW-1:0]   last_even = '0;
  logic [CW-1:0]   coefs   [NC];
  logic [2*CW-1:0] exp_mem [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write must coincide with an odd-index input handshake
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (in_valid && in_ready && !rst) begin
      check("wen_on_odd", 32'(bank_wen), 32'(hs_cnt % 2));
      if (bank_wen) begin
        wen_cnt++;
        check("wen_addr", 32'(bank_waddr), 32'(hs_cnt / 2));
        check("wen_data", 32'(bank_din), 32'({in_data, last_even}));
      end else begin
        last_even = in_data;
      end
      hs_cnt++;
    end else begin
      check("stray_wen", 32'(bank_wen), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic ld, input logic dp);
    start_load = ld;
    start_dump = dp;
    hs_cnt     = 0;
    tick();
    start_load = 1'b0;
    start_dump = 1'b0;
  endtask

  function automatic logic [CW-1:0] exp_coef(input int i);
    logic [2*CW-1:0] w;
    w = exp_mem[i / 2];
    return (i % 2 == 1) ? w[2*CW-1:CW] : w[CW-1:0];
  endfunction

  task automatic model_words(input int nwords);
    for (int k = 0; k < nwords; k++) exp_mem[k] = {coefs[2*k+1], coefs[2*k]};
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < int'(DEPTH); k++) check(tag, 32'(mem[k]), 32'(exp_mem[k]));
  endtask

  // Feeds coefs[0..n-1]; gap_pct sets the chance of an idle in_valid cycle
  task automatic load_coefs(input int gap_pct, input int n, input bit dump_pulse);
    int  i = 0;
    int  guard = 0;
    bit  hs;
    while (i < n && guard < 2000) begin
      in_valid   = ($urandom_range(99) >= 32'(gap_pct));
      in_data    = in_valid ? coefs[i] : CW'($urandom);
      start_dump = dump_pulse && (i == 10);
      hs         = in_valid && in_ready;
      tick();
      if (hs) i++;
      guard++;
    end
    in_valid   = 1'b0;
    start_dump = 1'b0;
    check("load_budget", 32'(guard < 2000), 32'd1);
  endtask

  // Runs a full dump, optionally stalling 7 cycles on coefficient stall_idx
  task automatic dump_check(input int stall_idx, input int rnd_pct);
    logic [CW-1:0] got[$];
    int guard = 0;
    int stall_left = 7;
    start_op(1'b0, 1'b1);
    while (got.size() < NC && guard < 3000) begin
      out_ready = ($urandom_range(99) >= 32'(rnd_pct));
      if (got.size() == stall_idx && stall_left > 0 && (out_valid || stall_left < 7)) begin
        out_ready = 1'b0;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(exp_coef(stall_idx)));
        stall_left--;
      end
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      guard++;
    end
    out_ready = 1'b0;
    check("dump_count", 32'(got.size()), 32'(NC));
    check("dump_done", 32'(done), 32'd1);
    for (int i = 0; i < got.size(); i++) check("dump_data", 32'(got[i]), 32'(exp_coef(i)));
    tick();
    check("dump_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int d0, w0;
    rst = 1'b1; start_load = 1'b0; start_dump = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_wen", 32'(bank_wen), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_waddr", 32'(bank_waddr), 32'd0);
    check("rst_din", 32'(bank_din), 32'd0);
    check("rst_raddr", 32'(bank_raddr), 32'd0);
    rst = 1'b0;
    tick();

    // Gap-free round trip of 0..63
    for (int i = 0; i < int'(NC); i++) coefs[i] = CW'(i);
    w0 = wen_cnt;
    start_op(1'b1, 1'b0);
    check("load_in_ready", 32'(in_ready), 32'd1);
    load_coefs(0, NC, 1'b0);
    check("load_done", 32'(done), 32'd1);
    check("load_wen_pulses", 32'(wen_cnt - w0), 32'd32);
    model_words(DEPTH);
    check("word5", 32'(mem[5]), 32'h00B00A);
    tick();
    check("load_done_clear", 32'(done), 32'd0);
    check("load_idle", 32'(busy), 32'd0);
    check_mem("rt_mem");
    dump_check(9, 0);

    // Random data with input gaps and output backpressure
    for (int i = 0; i < int'(NC); i++) coefs[i] = CW'($urandom);
    start_op(1'b1, 1'b0);
    load_coefs(40, NC, 1'b0);
    check("gap_done", 32'(done), 32'd1);
    model_words(DEPTH);
    tick();
    check_mem("gap_mem");
    dump_check(-1, 30);

    // Simultaneous starts, plus a start_dump pulse while busy
    for (int i = 0; i < int'(NC); i++) coefs[i] = CW'($urandom);
    d0 = done_cnt;
    start_op(1'b1, 1'b1);
    check("both_in_ready", 32'(in_ready), 32'd1);
    check("both_out_valid", 32'(out_valid), 32'd0);
    load_coefs(20, NC, 1'b1);
    check("both_done", 32'(done), 32'd1);
    tick(); tick(); tick();
    check("both_one_done", 32'(done_cnt - d0), 32'd1);
    check("both_idle", 32'(busy), 32'd0);
    check("both_no_dump", 32'(out_valid), 32'd0);
    model_words(DEPTH);
    check_mem("both_mem");
    dump_check(-1, 0);

    // Reset after 20 coefficients
    for (int i = 0; i < int'(NC); i++) coefs[i] = CW'($urandom);
    start_op(1'b1, 1'b0);
    load_coefs(0, 20, 1'b0);
    d0  = done_cnt;
    rst = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = CW'($urandom);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_wen", 32'(bank_wen), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    model_words(10);
    check_mem("abort_mem");
    dump_check(-1, 0);

    // Alternating all-ones / all-zeros coefficients
    for (int i = 0; i < int'(NC); i++) coefs[i] = (i % 2 == 0) ? 12'hFFF : 12'h000;
    start_op(1'b1, 1'b0);
    load_coefs(0, NC, 1'b0);
    check("bnd_done", 32'(done), 32'd1);
    model_words(DEPTH);
    tick();
    check("bnd_word0", 32'(mem[0]), 32'h000FFF);
    check("bnd_word31", 32'(mem[31]), 32'h000FFF);
    dump_check(3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
